// File: rtl/key_debounce_multi.sv
// Purpose: KEY_NUM independent debouncers for active-low mechanical keys; press/release/long pulses plus debounced level.
// Latency: key_press/key_release DEBOUNCE_CYC+3 edges after raw edge; key_long LONG_CYC cycles after key_press.
// Backpressure: none; outputs are single-cycle pulses and a level, consumer must sample every cycle.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   key_in      raw keys, 0 = pressed, asynchronous to clk
//   key_press   1-cycle pulse on accepted press
//   key_release 1-cycle pulse on accepted release
//   key_long    1-cycle pulse once a press has been held LONG_CYC cycles
//   key_level   debounced key state, 1 = pressed
//
// Optional build macro KEY_REPEAT_EN: key_long re-pulses every REPEAT_CYC cycles
// while the key stays held after the first long pulse.
module key_debounce_multi #(
    parameter int KEY_NUM      = 4,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int LONG_CYC     = 50_000_000,
    parameter int REPEAT_CYC   = 10_000_000,
    parameter int CNT_W        = 26
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_long,
    output logic [KEY_NUM-1:0] key_level
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HOLD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);

    // Elaboration-time parameter sanity checks.
    if (KEY_NUM < 1) begin : g_chk_num
        $error("key_debounce_multi: KEY_NUM must be >= 1");
    end
    if (DEBOUNCE_CYC < 2) begin : g_chk_db
        $error("key_debounce_multi: DEBOUNCE_CYC must be >= 2");
    end
    if (LONG_CYC <= DEBOUNCE_CYC) begin : g_chk_long
        $error("key_debounce_multi: LONG_CYC must exceed DEBOUNCE_CYC");
    end
    if (REPEAT_CYC < 1) begin : g_chk_rep
        $error("key_debounce_multi: REPEAT_CYC must be >= 1");
    end
    if ((longint'(LONG_CYC) >= (longint'(1) << CNT_W)) ||
        (longint'(REPEAT_CYC) >= (longint'(1) << CNT_W))) begin : g_chk_w
        $error("key_debounce_multi: CNT_W too narrow for cycle counts");
    end

    for (genvar g = 0; g < KEY_NUM; g++) begin : g_ch
        logic             sync1;
        logic             key_s;
        state_t           state;
        logic [CNT_W-1:0] db_cnt;
        logic [CNT_W-1:0] hold_cnt;
        // Remembers that the first long pulse of this press already fired, so
        // a saturated hold_cnt (or a release bounce back into HOLD) cannot re-fire it.
        logic             long_fired;
        logic             press_q;
        logic             release_q;
        logic             long_q;
        logic             level_q;
`ifdef KEY_REPEAT_EN
        localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYC - 1);
        logic [CNT_W-1:0] rep_cnt;
`endif

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1      <= 1'b1;
                key_s      <= 1'b1;
                state      <= IDLE;
                db_cnt     <= '0;
                hold_cnt   <= '0;
                long_fired <= 1'b0;
                press_q    <= 1'b0;
                release_q  <= 1'b0;
                long_q     <= 1'b0;
                level_q    <= 1'b0;
`ifdef KEY_REPEAT_EN
                rep_cnt    <= '0;
`endif
            end else begin
                sync1     <= key_in[g];
                key_s     <= sync1;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;

                case (state)
                    IDLE: begin
                        if (!key_s) begin
                            state  <= PRESS_DB;
                            db_cnt <= '0;
                        end
                    end

                    PRESS_DB: begin
                        if (key_s) begin
                            state  <= IDLE;
                            db_cnt <= '0;
                        end else if (db_cnt == DB_LAST) begin
                            state      <= HOLD;
                            press_q    <= 1'b1;
                            level_q    <= 1'b1;
                            db_cnt     <= '0;
                            hold_cnt   <= '0;
                            long_fired <= 1'b0;
`ifdef KEY_REPEAT_EN
                            rep_cnt    <= '0;
`endif
                        end else begin
                            db_cnt <= db_cnt + 1'b1;
                        end
                    end

                    HOLD: begin
                        if (hold_cnt != LONG_LAST) begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                        // The long pulse is tied to the hold time, not to key_s,
                        // so it still fires on the cycle a release debounce starts.
                        if (hold_cnt == LONG_LAST && !long_fired) begin
                            long_q     <= 1'b1;
                            long_fired <= 1'b1;
`ifdef KEY_REPEAT_EN
                            rep_cnt    <= '0;
                        end else if (long_fired) begin
                            if (rep_cnt == REP_LAST) begin
                                long_q  <= 1'b1;
                                rep_cnt <= '0;
                            end else begin
                                rep_cnt <= rep_cnt + 1'b1;
                            end
`endif
                        end
                        if (key_s) begin
                            state  <= RELEASE_DB;
                            db_cnt <= '0;
                        end
                    end

                    RELEASE_DB: begin
                        // hold_cnt (and rep_cnt) stay frozen here so a release
                        // bounce resumes the hold timing where it left off.
                        if (!key_s) begin
                            state  <= HOLD;
                            db_cnt <= '0;
                        end else if (db_cnt == DB_LAST) begin
                            state      <= IDLE;
                            release_q  <= 1'b1;
                            level_q    <= 1'b0;
                            db_cnt     <= '0;
                            hold_cnt   <= '0;
                            long_fired <= 1'b0;
`ifdef KEY_REPEAT_EN
                            rep_cnt    <= '0;
`endif
                        end else begin
                            db_cnt <= db_cnt + 1'b1;
                        end
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end

        assign key_press[g]   = press_q;
        assign key_release[g] = release_q;
        assign key_long[g]    = long_q;
        assign key_level[g]   = level_q;
    end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Purpose: directed self-checking bench for key_debounce_multi (DEBOUNCE_CYC=8, LONG_CYC=40, REPEAT_CYC=16).
// Latency: inputs driven on falling edges; outputs sampled on falling edges, one rising edge per step.
// Backpressure: none.
module tb_key_debounce_multi;

    localparam int KN = 4;

    logic          clk;
    logic          rst_n;
    logic [KN-1:0] key_in;
    logic [KN-1:0] key_press;
    logic [KN-1:0] key_release;
    logic [KN-1:0] key_long;
    logic [KN-1:0] key_level;

    logic [KN-1:0] seen_press;
    logic [KN-1:0] seen_release;
    logic [KN-1:0] seen_long;

    int checks;
    int errors;

    key_debounce_multi #(
        .KEY_NUM      (KN),
        .DEBOUNCE_CYC (8),
        .LONG_CYC     (40),
        .REPEAT_CYC   (16),
        .CNT_W        (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_in      (key_in),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long),
        .key_level   (key_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, sampling on each following falling edge and
    // accumulating any pulses seen.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            seen_press   = seen_press | key_press;
            seen_release = seen_release | key_release;
            seen_long    = seen_long | key_long;
        end
    endtask

    task automatic clear_seen();
        seen_press   = '0;
        seen_release = '0;
        seen_long    = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear_seen();
        rst_n  = 1'b0;
        key_in = '1;
        run(3);
        check("rst_press",   {28'd0, key_press},   32'h0);
        check("rst_release", {28'd0, key_release}, 32'h0);
        check("rst_long",    {28'd0, key_long},    32'h0);
        check("rst_level",   {28'd0, key_level},   32'h0);
        rst_n = 1'b1;
        run(3);

        // Clean press / release on channel 0.
        key_in = 4'b1110;
        clear_seen();
        run(10);
        check("clean_press_early", {28'd0, seen_press}, 32'h0);
        run(1);
        check("clean_press_at11", {28'd0, key_press}, 32'h1);
        check("clean_level_hi",   {28'd0, key_level}, 32'h1);
        run(1);
        check("clean_press_1cyc", {28'd0, key_press}, 32'h0);
        run(8);
        key_in = 4'b1111;
        run(10);
        check("clean_rel_early",  {28'd0, seen_release}, 32'h0);
        check("clean_level_held", {28'd0, key_level},    32'h1);
        run(1);
        check("clean_rel_at11",   {28'd0, key_release}, 32'h1);
        check("clean_level_lo",   {28'd0, key_level},   32'h0);
        run(9);
        check("clean_no_long",    {28'd0, seen_long},   32'h0);

        // Press bounce on channel 1: never accepted.
        clear_seen();
        key_in = 4'b1101; run(5);
        key_in = 4'b1111; run(2);
        key_in = 4'b1101; run(5);
        key_in = 4'b1111; run(20);
        check("bounce_no_pulse", {28'd0, seen_press | seen_release | seen_long}, 32'h0);
        check("bounce_level",    {28'd0, key_level}, 32'h0);
        // Channel 1 is back in IDLE: a clean press is accepted on normal timing.
        key_in = 4'b1101;
        run(10);
        check("bounce_idle_early", {28'd0, seen_press}, 32'h0);
        run(1);
        check("bounce_idle_press", {28'd0, key_press}, 32'h2);
        key_in = 4'b1111;
        run(12);

        // Long press on channel 2.
        clear_seen();
        key_in = 4'b1011;
        run(11);
        check("long_press", {28'd0, key_press}, 32'h4);
        run(39);
        check("long_early", {28'd0, seen_long}, 32'h0);
        run(1);
        check("long_at40",  {28'd0, key_long}, 32'h4);
        run(1);
        check("long_1cyc",  {28'd0, key_long}, 32'h0);
        clear_seen();
`ifdef KEY_REPEAT_EN
        run(14);
        check("long_rep_early", {28'd0, seen_long}, 32'h0);
        run(1);
        check("long_repeat",    {28'd0, key_long},  32'h4);
        run(5);
`else
        run(20);
        check("long_no_repeat", {28'd0, seen_long}, 32'h0);
`endif
        clear_seen();
        key_in = 4'b1111;
        run(12);
        check("long_release",   {28'd0, seen_release}, 32'h4);
        check("long_rel_quiet", {28'd0, seen_long},    32'h0);

        // Release bounce on channel 3.
        key_in = 4'b0111;
        run(11);
        check("rb_press", {28'd0, key_press}, 32'h8);
        run(5);
        clear_seen();
        key_in = 4'b1111; run(4);
        key_in = 4'b0111; run(3);
        key_in = 4'b1111;
        run(10);
        check("rb_no_early_rel", {28'd0, seen_release}, 32'h0);
        check("rb_no_press",     {28'd0, seen_press | seen_long}, 32'h0);
        check("rb_level_held",   {28'd0, key_level}, 32'h8);
        run(1);
        check("rb_release",      {28'd0, key_release}, 32'h8);
        check("rb_level_lo",     {28'd0, key_level},   32'h0);
        clear_seen();
        run(10);
        check("rb_single_rel",   {28'd0, seen_release}, 32'h0);

        // Simultaneous channels 0 and 3.
        clear_seen();
        key_in = 4'b0110;
        run(10);
        check("sim_early", {28'd0, seen_press}, 32'h0);
        run(1);
        check("sim_press", {28'd0, key_press}, 32'h9);
        check("sim_level", {28'd0, key_level}, 32'h9);
        key_in = 4'b1111;
        run(12);
        check("sim_release", {28'd0, seen_release}, 32'h9);
        check("sim_ch12_quiet", {28'd0, (seen_press | seen_release | seen_long) & 4'b0110}, 32'h0);

        // Reset while channel 0 is in HOLD.
        key_in = 4'b1110;
        run(11);
        check("rst_mid_press", {28'd0, key_press}, 32'h1);
        run(20);
        rst_n = 1'b0;
        #1;
        check("rst_mid_level", {28'd0, key_level}, 32'h0);
        check("rst_mid_pulses", {28'd0, key_press | key_release | key_long}, 32'h0);
        run(2);
        rst_n = 1'b1;
        clear_seen();
        run(10);
        check("rst_re_early", {28'd0, seen_press}, 32'h0);
        run(1);
        check("rst_re_press", {28'd0, key_press}, 32'h1);
        key_in = 4'b1111;
        run(12);
        check("rst_re_release", {28'd0, seen_release}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
